gf163_mult_io: RTL and testbench
================================

# gf163_mult_io

Word-serial front/back end for the GF(2^163) interleaved multiplier. Accepts operands A and B as 32-bit words over a valid/ready stream and drives the multiplier's A/B/start/reset pins. Captures the 163-bit product on the multiplier's done pulse and returns it as 32-bit words over a second valid/ready stream. It sits between the SoC bus adapter and the multiplier, and supervises each run with a timeout.

## Interface
- WORD_W, 32, stream word width
- M, 163, field degree / operand width
- NWORDS, 6, words per operand (ceil(M/WORD_W))
- TIMEOUT, 400, max cycles in RUN before abort
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  WORD_W  operand word, LSW first; A words 0-5, then B words 0-5
- out_valid  out  1  result word valid
- out_ready  in  1  result word consumed when out_valid && out_ready
- out_data  out  WORD_W  result word, LSW first
- mult_a, mult_b  out  M  operands to the multiplier, held stable from CLEAR to end of RUN
- mult_rst  out  1  active-high clear to the multiplier, registered one-cycle pulse
- mult_start  out  1  multiplier start, held high for the whole run
- mult_z  in  M  multiplier product
- mult_done  in  1  multiplier completion pulse
- busy  out  1  high in CLEAR and RUN
- err  out  1  sticky timeout flag

## Operation
- States: COLLECT, CLEAR, RUN, DRAIN. Reset state is COLLECT.
- COLLECT
  - in_ready=1.
  - 4-bit word counter wcnt 0..11.
  - Word k<6 is written to A[32k+:32] and word k≥6 to B[32(k-6)+:32], truncated to M bits. Bits 31:3 of words 5 and 11 are ignored.
  - Acceptance of word 0 clears err.
  - Acceptance of word 11 moves to CLEAR.
- CLEAR
  - mult_rst=1 for exactly one cycle, which clears the multiplier's sticky completion flag.
  - Moves to RUN.
- RUN
  - mult_start=1 and the timeout counter increments each cycle.
  - On mult_done=1: capture mult_z into the result register, drop mult_start the next cycle, go to DRAIN.
  - If the counter reaches TIMEOUT without mult_done: result register is cleared to 0, err=1, mult_start drops, go to DRAIN.
- DRAIN
  - out_valid=1. out_data = result[32j+:32] for j = 0..5; word 5 is zero-extended above bit 2.
  - j advances only on handshake. out_data is stable while out_valid && !out_ready.
  - The handshake on j=5 returns to COLLECT.
- in_ready=0 outside COLLECT. There is no overlap of input and output phases.
- mult_done outside RUN is ignored.

## Timing
- Reset values: out_valid=0, mult_start=0, mult_rst=0, busy=0, err=0, out_data=0, mult_a=mult_b=0, wcnt=0. in_ready=1 (COLLECT).
- rst_n low at any point (including mid-RUN or mid-DRAIN) forces the reset values immediately. A partially collected operand is discarded.
- Registered outputs: mult_start, mult_rst, out_valid, out_data, busy, err.
- Sequence from the handshake on input word 11 (cycle t):
  - CLEAR at t+1, mult_rst high during t+1.
  - RUN and mult_start high from t+2.
  - Nominal multiplier completion is 167 cycles, so TIMEOUT=400 leaves margin.
- mult_done sampled at cycle d: out_valid=1 and mult_start=0 from d+1.
- With out_ready tied high, DRAIN takes 6 cycles; in_ready rises the cycle after the last out handshake.
- Timeout counter is 9 bits and saturates at TIMEOUT. mult_done arriving in the same cycle as the timeout wins: result captured, err stays 0.

## Structure
- Shared package gf163_pkg:
  - constants M=163, WORD_W=32, NWORDS=6, reduction polynomial tail 8'hC9 (x^7+x^6+x^3+1)
  - the 2-bit state encoding
- No internal sub-module. The multiplier is instantiated beside this block in the parent, and mult_rst is ORed with the system reset there.
- Operand and result word selection use indexed part-selects, not shift chains.

## Test plan
- A=1, B=1 (words 1,0,0,0,0,0 each) → out words 1,0,0,0,0,0; err=0.
- A=x^162 (word5=0x4), B=x (word0=0x2) → out word0=0xC9, others 0.
- Word 5 of A sent as 0xFFFFFFFC with the other A words 0, B=1 → out word5=0x4, words 0-4=0 (high bits ignored).
- Same operands with out_ready low 3 cycles before each word → 6 handshakes exactly, out_data stable while stalled, identical result.
- mult_done tied 0 → mult_start falls TIMEOUT cycles after rising, err=1, six zero words. The next transaction clears err on word 0 and returns a correct product.
- rst_n pulsed low 50 cycles into RUN → all outputs at reset values during reset. A following full A=1, B=1 transaction returns 1.

Source files
------------

// File: rtl/gf163_pkg.sv
// Shared constants, state encoding and word select/insert helpers for the
// GF(2^163) multiplier word-serial I/O block.
package gf163_pkg;

  localparam int M      = 163;
  localparam int WORD_W = 32;
  localparam int NWORDS = 6;
  localparam int PAD_W  = NWORDS * WORD_W;

  // x^163 + x^7 + x^6 + x^3 + 1, low byte of the reduction polynomial
  localparam logic [7:0] POLY_TAIL = 8'hC9;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] word_sel(input logic [M-1:0] v,
                                                 input logic [2:0]   idx);
    logic [PAD_W-1:0] pad;
    pad = {{(PAD_W-M){1'b0}}, v};
    return pad[WORD_W*idx +: WORD_W];
  endfunction

  // Bits above M-1 in the top word fall off when the padded vector is truncated
  function automatic logic [M-1:0] word_ins(input logic [M-1:0]      v,
                                            input logic [2:0]        idx,
                                            input logic [WORD_W-1:0] w);
    logic [PAD_W-1:0] pad;
    pad = {{(PAD_W-M){1'b0}}, v};
    pad[WORD_W*idx +: WORD_W] = w;
    return pad[M-1:0];
  endfunction

endpackage

// File: rtl/gf163_mult_io.sv
// Word-serial operand loader / product unloader wrapped around the GF(2^163)
// multiplier, with a run timeout that aborts to an all-zero result.
module gf163_mult_io
  import gf163_pkg::*;
#(
  parameter int TIMEOUT = 400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [M-1:0]      mult_a,
  output logic [M-1:0]      mult_b,
  output logic              mult_rst,
  output logic              mult_start,
  input  logic [M-1:0]      mult_z,
  input  logic              mult_done,
  output logic              busy,
  output logic              err
);

  localparam logic [8:0] TMO = 9'(TIMEOUT);

  state_t            state_r, state_nxt_s;
  logic [3:0]        wcnt_r, wcnt_nxt_s;
  logic [2:0]        jcnt_r, jcnt_nxt_s;
  logic [8:0]        tcnt_r, tcnt_nxt_s, tcnt_inc_s;
  logic [M-1:0]      a_r, a_nxt_s, b_r, b_nxt_s, res_r, res_nxt_s;
  logic              start_r, start_nxt_s, mrst_r, mrst_nxt_s;
  logic              oval_r, oval_nxt_s, busy_r, busy_nxt_s, err_r, err_nxt_s;
  logic [WORD_W-1:0] odata_r, odata_nxt_s;

  assign in_ready   = (state_r == ST_COLLECT);
  assign out_valid  = oval_r;
  assign out_data   = odata_r;
  assign mult_a     = a_r;
  assign mult_b     = b_r;
  assign mult_rst   = mrst_r;
  assign mult_start = start_r;
  assign busy       = busy_r;
  assign err        = err_r;

  // Next-state and next-output logic for the collect/clear/run/drain sequence
  always_comb begin
    state_nxt_s = state_r;
    wcnt_nxt_s  = wcnt_r;
    jcnt_nxt_s  = jcnt_r;
    tcnt_nxt_s  = tcnt_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    res_nxt_s   = res_r;
    start_nxt_s = start_r;
    mrst_nxt_s  = 1'b0;
    oval_nxt_s  = oval_r;
    odata_nxt_s = odata_r;
    busy_nxt_s  = busy_r;
    err_nxt_s   = err_r;
    tcnt_inc_s  = (tcnt_r == TMO) ? tcnt_r : tcnt_r + 9'd1;

    case (state_r)
      ST_COLLECT: begin
        if (in_valid) begin
          if (wcnt_r < 4'd6) begin
            a_nxt_s = word_ins(a_r, wcnt_r[2:0], in_data);
          end else begin
            b_nxt_s = word_ins(b_r, 3'(wcnt_r - 4'd6), in_data);
          end
          if (wcnt_r == 4'd0) begin
            err_nxt_s = 1'b0;
          end else begin
            err_nxt_s = err_r;
          end
          if (wcnt_r == 4'd11) begin
            wcnt_nxt_s  = 4'd0;
            state_nxt_s = ST_CLEAR;
            mrst_nxt_s  = 1'b1;
            busy_nxt_s  = 1'b1;
          end else begin
            wcnt_nxt_s = wcnt_r + 4'd1;
          end
        end else begin
          wcnt_nxt_s = wcnt_r;
        end
      end
      ST_CLEAR: begin
        state_nxt_s = ST_RUN;
        start_nxt_s = 1'b1;
        tcnt_nxt_s  = 9'd0;
      end
      ST_RUN: begin
        tcnt_nxt_s = tcnt_inc_s;
        // a done pulse coinciding with the final timeout cycle still wins
        if (mult_done) begin
          res_nxt_s   = mult_z;
          odata_nxt_s = word_sel(mult_z, 3'd0);
          start_nxt_s = 1'b0;
          busy_nxt_s  = 1'b0;
          oval_nxt_s  = 1'b1;
          jcnt_nxt_s  = 3'd0;
          state_nxt_s = ST_DRAIN;
        end else if (tcnt_inc_s == TMO) begin
          res_nxt_s   = '0;
          odata_nxt_s = {WORD_W{1'b0}};
          err_nxt_s   = 1'b1;
          start_nxt_s = 1'b0;
          busy_nxt_s  = 1'b0;
          oval_nxt_s  = 1'b1;
          jcnt_nxt_s  = 3'd0;
          state_nxt_s = ST_DRAIN;
        end else begin
          start_nxt_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (jcnt_r == 3'd5) begin
            oval_nxt_s  = 1'b0;
            odata_nxt_s = {WORD_W{1'b0}};
            jcnt_nxt_s  = 3'd0;
            state_nxt_s = ST_COLLECT;
          end else begin
            jcnt_nxt_s  = jcnt_r + 3'd1;
            odata_nxt_s = word_sel(res_r, jcnt_r + 3'd1);
          end
        end else begin
          odata_nxt_s = odata_r;
        end
      end
      default: begin
        state_nxt_s = ST_COLLECT;
      end
    endcase
  end

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_COLLECT;
      wcnt_r  <= 4'd0;
      jcnt_r  <= 3'd0;
      tcnt_r  <= 9'd0;
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      start_r <= 1'b0;
      mrst_r  <= 1'b0;
      oval_r  <= 1'b0;
      odata_r <= {WORD_W{1'b0}};
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      wcnt_r  <= wcnt_nxt_s;
      jcnt_r  <= jcnt_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      res_r   <= res_nxt_s;
      start_r <= start_nxt_s;
      mrst_r  <= mrst_nxt_s;
      oval_r  <= oval_nxt_s;
      odata_r <= odata_nxt_s;
      busy_r  <= busy_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_gf163_mult_io.sv
// Randomised self-checking bench for gf163_mult_io with a behavioural
// GF(2^163) multiplier standing in for the real core.
module tb_gf163_mult_io;
  import gf163_pkg::*;

  localparam int TMO = 400;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_data;
  logic [M-1:0]      mult_a, mult_b, mult_z;
  logic              mult_rst, mult_start, mult_done, busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WORD_W-1:0] tx_words[12];
  logic [WORD_W-1:0] rx_words[6];
  logic [M-1:0]      exp_prod;
  bit  obs_hang, obs_clear_ok, obs_run_ok, obs_valid_d1, obs_stable, obs_post_ok, obs_err_w0;
  int  obs_start_len;

  gf163_mult_io #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .mult_a(mult_a), .mult_b(mult_b), .mult_rst(mult_rst),
    .mult_start(mult_start), .mult_z(mult_z), .mult_done(mult_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-1:0] p, poly;
    p = '0;
    poly = '0;
    poly[M] = 1'b1;
    poly[7:0] = POLY_TAIL;
    for (int i = 0; i < M; i++)
      if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) p = p ^ (poly << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_m();
    logic [PAD_W-1:0] r;
    for (int i = 0; i < NWORDS; i++) r[32*i +: 32] = $urandom();
    return r[M-1:0];
  endfunction

  function automatic logic [M-1:0] operand_from_words(input int base);
    logic [PAD_W-1:0] r;
    for (int i = 0; i < NWORDS; i++) r[32*i +: 32] = tx_words[base+i];
    return r[M-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] exp_word(input int j);
    logic [PAD_W-1:0] r;
    r = {{(PAD_W-M){1'b0}}, exp_prod};
    return r[32*j +: 32];
  endfunction

  task automatic load_ops(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [PAD_W-1:0] pa, pb;
    pa = {{(PAD_W-M){1'b0}}, a};
    pb = {{(PAD_W-M){1'b0}}, b};
    for (int i = 0; i < 6; i++) begin
      tx_words[i]   = pa[32*i +: 32];
      tx_words[6+i] = pb[32*i +: 32];
    end
  endtask

  task automatic send_words();
    int n;
    obs_hang = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) obs_err_w0 = err;
      in_valid = 1'b1;
      in_data  = tx_words[k];
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) obs_hang = 1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  // Full transaction: load, clear/run with a stub multiplier, then drain
  task automatic do_txn(input int lat, input bit done_en, input int stall);
    int cyc, n;
    logic [WORD_W-1:0] held;
    exp_prod = done_en ? gf_mul(operand_from_words(0), operand_from_words(6)) : '0;
    obs_stable = 1;
    held = '0;
    send_words();
    obs_clear_ok = mult_rst && !mult_start && busy && !in_ready;
    @(negedge clk);
    obs_run_ok = mult_start && !mult_rst && busy;
    cyc = 0;
    while (mult_start && cyc < 1000) begin
      cyc++;
      if (done_en && cyc == lat) begin
        mult_done = 1'b1;
        mult_z    = gf_mul(mult_a, mult_b);
      end else begin
        mult_done = 1'b0;
        mult_z    = rand_m();
      end
      @(negedge clk);
    end
    mult_done = 1'b0;
    obs_start_len = cyc;
    obs_valid_d1  = out_valid && !busy;
    for (int j = 0; j < 6; j++) begin
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        if (s == 0) held = out_data;
        else if (out_data !== held || !out_valid) obs_stable = 0;
        mult_done = 1'b1;
        mult_z    = rand_m();
        @(negedge clk);
      end
      mult_done = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) obs_hang = 1;
      if (stall > 0 && out_data !== held) obs_stable = 0;
      rx_words[j] = out_data;
      @(negedge clk);
    end
    out_ready = 1'b0;
    obs_post_ok = in_ready && !out_valid && !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_cmp++; if ({in_ready, out_valid, mult_start, mult_rst, busy, err} !== 6'b100000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 100000", {in_ready, out_valid, mult_start, mult_rst, busy, err}); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (mult_a !== '0 || mult_b !== '0) begin n_bad++; $display("FAIL reset_operands got a=%h b=%h want 0", mult_a, mult_b); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    load_ops(163'd1, 163'd1);
    do_txn(167, 1'b1, 0);
    n_cmp++; if (obs_hang) begin n_bad++; $display("FAIL ident_hang got stuck want progress"); end
    n_cmp++; if (!obs_clear_ok) begin n_bad++; $display("FAIL ident_clear got 0 want mult_rst pulse at t+1"); end
    n_cmp++; if (!obs_run_ok) begin n_bad++; $display("FAIL ident_run got 0 want mult_start at t+2"); end
    n_cmp++; if (obs_start_len !== 167) begin n_bad++; $display("FAIL ident_start_len got %0d want 167", obs_start_len); end
    n_cmp++; if (!obs_valid_d1) begin n_bad++; $display("FAIL ident_valid_d1 got 0 want 1"); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (rx_words[j] !== ((j == 0) ? 32'd1 : 32'd0)) begin
        n_bad++; $display("FAIL ident_word%0d got %h want %h", j, rx_words[j], (j == 0) ? 32'd1 : 32'd0); end
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ident_err got %b want 0", err); end
    n_cmp++; if (!obs_post_ok) begin n_bad++; $display("FAIL ident_post got 0 want in_ready back"); end
  endtask

  task automatic test_reduction();
    logic [M-1:0] a;
    a = '0;
    a[M-1] = 1'b1;
    load_ops(a, 163'd2);
    do_txn($urandom_range(1, 200), 1'b1, 0);
    n_cmp++; if (rx_words[0] !== 32'hC9) begin n_bad++; $display("FAIL reduce_word0 got %h want c9", rx_words[0]); end
    for (int j = 1; j < 6; j++) begin
      n_cmp++; if (rx_words[j] !== 32'd0) begin n_bad++; $display("FAIL reduce_word%0d got %h want 0", j, rx_words[j]); end
    end
  endtask

  task automatic test_truncation(input int stall);
    load_ops('0, 163'd1);
    tx_words[5] = 32'hFFFF_FFFC;
    do_txn($urandom_range(1, 200), 1'b1, stall);
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (rx_words[j] !== ((j == 5) ? 32'd4 : 32'd0)) begin
        n_bad++; $display("FAIL trunc_s%0d_word%0d got %h want %h", stall, j, rx_words[j], (j == 5) ? 32'd4 : 32'd0); end
    end
    n_cmp++; if (!obs_stable) begin n_bad++; $display("FAIL trunc_s%0d_stable got unstable want stable", stall); end
    n_cmp++; if (!obs_post_ok || obs_hang) begin n_bad++; $display("FAIL trunc_s%0d_handshakes got extra/missing want 6", stall); end
  endtask

  task automatic test_random(input int iters);
    int lat, stall;
    for (int it = 0; it < iters; it++) begin
      lat   = $urandom_range(1, 300);
      stall = $urandom_range(0, 2);
      load_ops(rand_m(), rand_m());
      if (it == 0) tx_words[11] = $urandom();
      do_txn(lat, 1'b1, stall);
      for (int j = 0; j < 6; j++) begin
        n_cmp++; if (rx_words[j] !== exp_word(j)) begin
          n_bad++; $display("FAIL rand%0d_word%0d got %h want %h", it, j, rx_words[j], exp_word(j)); end
      end
      n_cmp++; if (obs_start_len !== lat || err !== 1'b0) begin
        n_bad++; $display("FAIL rand%0d_run got len=%0d err=%b want len=%0d err=0", it, obs_start_len, err, lat); end
      n_cmp++; if (!obs_stable || !obs_post_ok) begin
        n_bad++; $display("FAIL rand%0d_drain got stable=%b post=%b want 1/1", it, obs_stable, obs_post_ok); end
    end
  endtask

  task automatic test_timeout();
    load_ops(rand_m(), rand_m());
    do_txn(0, 1'b0, 0);
    n_cmp++; if (obs_start_len !== TMO) begin n_bad++; $display("FAIL tmo_start_len got %0d want %0d", obs_start_len, TMO); end
    n_cmp++; if (err !== 1'b1 || !obs_valid_d1) begin n_bad++; $display("FAIL tmo_err got err=%b valid=%b want 1/1", err, obs_valid_d1); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (rx_words[j] !== 32'd0) begin n_bad++; $display("FAIL tmo_word%0d got %h want 0", j, rx_words[j]); end
    end
    load_ops(rand_m(), rand_m());
    do_txn($urandom_range(1, 200), 1'b1, 0);
    n_cmp++; if (obs_err_w0 !== 1'b0) begin n_bad++; $display("FAIL tmo_err_clear got %b want 0", obs_err_w0); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (rx_words[j] !== exp_word(j)) begin
        n_bad++; $display("FAIL tmo_next_word%0d got %h want %h", j, rx_words[j], exp_word(j)); end
    end
  endtask

  task automatic test_reset_midrun();
    load_ops(rand_m(), rand_m());
    send_words();
    repeat (51) begin
      mult_z = rand_m();
      @(negedge clk);
    end
    n_cmp++; if (mult_start !== 1'b1) begin n_bad++; $display("FAIL midrun_running got %b want 1", mult_start); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid, mult_start, mult_rst, busy, err} !== 6'b100000 || out_data !== '0 || mult_a !== '0 || mult_b !== '0) begin
      n_bad++; $display("FAIL midrun_reset got %b want 100000 with zero data", {in_ready, out_valid, mult_start, mult_rst, busy, err}); end
    @(negedge clk);
    rst_n = 1'b1;
    load_ops(163'd1, 163'd1);
    do_txn($urandom_range(1, 200), 1'b1, 0);
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (rx_words[j] !== ((j == 0) ? 32'd1 : 32'd0)) begin
        n_bad++; $display("FAIL midrun_after_word%0d got %h want %h", j, rx_words[j], (j == 0) ? 32'd1 : 32'd0); end
    end
  endtask

  initial begin
    mult_done = 1'b0;
    mult_z    = '0;
    test_reset();
    test_identity();
    test_reduction();
    test_truncation(0);
    test_truncation(3);
    test_random(5);
    test_timeout();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
